// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       busy,
  output logic       tx
);

  // Stop phase may last 32 ticks, so the tick counter widens when needed.
  localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;

  localparam logic [SW-1:0] TickLast = SW'(15);
  localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
  localparam logic [2:0]    BitLast  = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state;
  logic [SW-1:0]   s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] b_reg;
  logic            tx_reg;
`ifdef UART_TX_PARITY_EN
  logic            par_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= StIdle;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      tx_reg       <= 1'b1;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      unique case (state)
        StIdle: begin
          if (tx_start) begin
            state  <= StStart;
            s_cnt  <= '0;
            b_reg  <= din[DBIT-1:0];
            tx_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg <= ^din[DBIT-1:0];
`endif
          end
        end
        StStart: begin
          if (s_tick) begin
            if (s_cnt == TickLast) begin
              state  <= StData;
              s_cnt  <= '0;
              n_cnt  <= '0;
              tx_reg <= b_reg[0];
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (s_cnt == TickLast) begin
              s_cnt <= '0;
              b_reg <= b_reg >> 1;
              if (n_cnt == BitLast) begin
`ifdef UART_TX_PARITY_EN
                state  <= StParity;
                tx_reg <= par_reg;
`else
                state  <= StStop;
                tx_reg <= 1'b1;
`endif
              end else begin
                n_cnt  <= n_cnt + 1'b1;
                // Next bit to present is the one about to shift into position 0.
                tx_reg <= b_reg[1];
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (s_tick) begin
            if (s_cnt == TickLast) begin
              state  <= StStop;
              s_cnt  <= '0;
              tx_reg <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`endif
        StStop: begin
          tx_reg <= 1'b1;
          if (s_tick) begin
            if (s_cnt == StopLast) begin
              state        <= StIdle;
              s_cnt        <= '0;
              tx_done_tick <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy = (state != StIdle);
  assign tx   = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line bits are queued at each start and popped at mid-bit samples.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

  localparam int unsigned DBIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick = 1'b0;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_done_tick;
  logic       busy;
  logic       tx;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic tick_en = 1'b0;
  int   div = 0;
  logic exp_q[$];

  uart_tx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // One-clk tick every 16 clocks, changed on the falling edge.
  always @(negedge clk) begin
    if (!tick_en) begin
      s_tick = 1'b0;
      div    = 0;
    end else begin
      s_tick = (div == 15);
      div    = (div == 15) ? 0 : div + 1;
    end
  end

  always @(posedge clk) if (tx_done_tick) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume n tick edges; leaves time at #1 after the last one.
  task automatic wait_ticks(input int n);
    int got   = 0;
    int guard = 0;
    while (got < n && guard < 5000) begin
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      guard++;
      if (s_tick) got++;
    end
    if (got < n) chk("tick_timeout", 32'(got), 32'(n));
  endtask

  task automatic launch(input logic [7:0] d);
    din      = d;
    tx_start = 1'b1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DBIT; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    chk("start_tx", tx, 0);
    chk("start_busy", busy, 1);
    chk("start_done", tx_done_tick, 0);
  endtask

  // Samples each bit at its 8th tick; optional stray start or tick stall after bit k.
  task automatic check_frame(input int stall_bit, input int inject_bit);
    int   nb;
    logic e;
    nb = exp_q.size();
    wait_ticks(8);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) wait_ticks(16);
      e = exp_q.pop_front();
      chk($sformatf("bit%0d", i), tx, e);
      if (i == inject_bit) begin
        tx_start = 1'b1;
        din      = 8'hFF;
      end
      if (i == stall_bit) begin
        tick_en = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("stall_tx", tx, e);
        chk("stall_busy", busy, 1);
        tick_en = 1'b1;
      end
    end
    wait_ticks(8);
    chk("end_done", tx_done_tick, 1);
    chk("end_busy", busy, 0);
    chk("end_tx", tx, 1);
  endtask

  task automatic idle_check(input int exp_cnt);
    @(posedge clk);
    #1;
    chk("done_pulse_width", tx_done_tick, 0);
    chk("done_count", 32'(done_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int d0;
    rst      = 1'b0;
    tx_start = 1'b0;
    din      = 8'h00;
    tick_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done_tick, 0);
    rst = 1'b1;

    // Abort a frame in progress with a 2-clk reset.
    d0 = done_cnt;
    launch(8'h5A);
    wait_ticks(40);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", tx_done_tick, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3000) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_idle_tx", tx, 1);

    d0 = done_cnt;
    launch(8'hA5);
    check_frame(-1, -1);
    idle_check(d0 + 1);

    // Stray start with 8'hFF during data, plus a 1000-clk tick stall.
    d0 = done_cnt;
    launch(8'h00);
    check_frame(5, 3);
    idle_check(d0 + 1);

    // Splitter of 16'h1234: low byte first, next start on the done pulse.
    d0 = done_cnt;
    launch(8'h34);
    check_frame(-1, -1);
    launch(8'h12);
    check_frame(-1, -1);
    idle_check(d0 + 2);

`ifdef UART_TX_PARITY_EN
    d0 = done_cnt;
    launch(8'h07);
    check_frame(-1, -1);
    idle_check(d0 + 1);
    launch(8'h03);
    check_frame(-1, -1);
    idle_check(d0 + 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
